// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: deserialises pre-sampled bits, checks parity and
// stop bits, and keeps a saturating count of errored frames.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  bit_valid,
  input  logic                  rxin,
  input  logic [1:0]            parity_mode,
  input  logic                  clr_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parityerror,
  output logic                  frameerror,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bitCnt;
  logic                  r_stopCnt;
  logic [1:0]            r_mode;
  logic                  r_parErr;
  logic                  r_frmErr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_doutValid;
  logic                  r_parityError;
  logic                  r_frameError;
  logic [CNT_WIDTH-1:0]  r_errCount;

  logic w_sample;
  logic w_lastData;
  logic w_lastStop;
  logic w_expParity;
  logic w_start;
  logic w_shiftEn;
  logic w_parSample;
  logic w_stopSample;
  logic w_done;
  logic w_frameBad;
  logic w_anyErr;
  logic w_busy;

  assign w_sample   = load & bit_valid;
  assign w_lastData = (r_bitCnt == BCW'(DATA_WIDTH - 1));
  assign w_lastStop = (r_stopCnt == 1'(STOP_BITS - 1));

  always_comb begin
    w_expParity = 1'b1;
    case (r_mode)
      2'b01:   w_expParity = ^r_shift;
      2'b10:   w_expParity = ~(^r_shift);
      default: w_expParity = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Dropping load aborts a frame from any non-idle state without waiting for a bit strobe.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_sample && !rxin) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (!load) begin
          w_nextState = IDLE;
        end else if (bit_valid && w_lastData) begin
          w_nextState = (r_mode != 2'b00) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (!load) begin
          w_nextState = IDLE;
        end else if (bit_valid) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (!load) begin
          w_nextState = IDLE;
        end else if (bit_valid && w_lastStop) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != IDLE);
    w_start      = 1'b0;
    w_shiftEn    = 1'b0;
    w_parSample  = 1'b0;
    w_stopSample = 1'b0;
    case (r_state)
      IDLE:    w_start      = w_sample & ~rxin;
      DATA:    w_shiftEn    = w_sample;
      PARITY:  w_parSample  = w_sample;
      STOP:    w_stopSample = w_sample;
      default: w_start      = 1'b0;
    endcase
  end

  assign w_done     = w_stopSample & w_lastStop;
  assign w_frameBad = r_frmErr | ~rxin;
  assign w_anyErr   = r_parErr | w_frameBad;

  // The final stop bit is folded in combinationally so results publish on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift       <= '0;
      r_bitCnt      <= '0;
      r_stopCnt     <= 1'b0;
      r_mode        <= 2'b00;
      r_parErr      <= 1'b0;
      r_frmErr      <= 1'b0;
      r_dout        <= '0;
      r_doutValid   <= 1'b0;
      r_parityError <= 1'b0;
      r_frameError  <= 1'b0;
    end else begin
      r_doutValid <= 1'b0;
      if (w_start) begin
        r_bitCnt  <= '0;
        r_stopCnt <= 1'b0;
        r_mode    <= parity_mode;
        r_parErr  <= 1'b0;
        r_frmErr  <= 1'b0;
      end
      if (w_shiftEn) begin
        r_shift  <= {rxin, r_shift[DATA_WIDTH-1:1]};
        r_bitCnt <= r_bitCnt + 1'b1;
      end
      if (w_parSample && (rxin != w_expParity)) begin
        r_parErr <= 1'b1;
      end
      if (w_stopSample) begin
        r_stopCnt <= r_stopCnt + 1'b1;
        if (!rxin) begin
          r_frmErr <= 1'b1;
        end
      end
      if (w_done) begin
        r_dout        <= r_shift;
        r_doutValid   <= 1'b1;
        r_parityError <= r_parErr;
        r_frameError  <= w_frameBad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_errCount <= '0;
    end else if (clr_count) begin
      r_errCount <= '0;
    end else if (w_done && w_anyErr && (r_errCount != {CNT_WIDTH{1'b1}})) begin
      r_errCount <= r_errCount + 1'b1;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_doutValid;
  assign parityerror = r_parityError;
  assign frameerror  = r_frameError;
  assign busy        = w_busy;
  assign err_count   = r_errCount;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Scoreboard bench for uart_rx_frame_checker (8 data bits, 2 stop bits, 2-bit
// error counter): directed frames push expectations, a monitor checks each pulse.
module tb_uart_rx_frame_checker;

  logic       clk;
  logic       reset;
  logic       load;
  logic       bit_valid;
  logic       rxin;
  logic [1:0] parity_mode;
  logic       clr_count;
  logic [7:0] dout;
  logic       dout_valid;
  logic       parityerror;
  logic       frameerror;
  logic       busy;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;
  int errModel = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       parBit;
    logic       s0;
    logic       s1;
    logic       clr;
    logic       expPar;
    logic       expFrm;
    int         gap;
  } frame_t;

  typedef struct {
    logic [7:0] dout;
    logic       par;
    logic       frm;
    logic [1:0] cnt;
  } expect_t;

  expect_t sbQueue[$];
  logic [7:0] lastDout;

  uart_rx_frame_checker #(
    .DATA_WIDTH(8),
    .STOP_BITS (2),
    .CNT_WIDTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bit_valid  (bit_valid),
    .rxin       (rxin),
    .parity_mode(parity_mode),
    .clr_count  (clr_count),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parityerror(parityerror),
    .frameerror (frameerror),
    .busy       (busy),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every dout_valid pulse must match the oldest outstanding expectation.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid === 1'b1) begin
        if (sbQueue.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_pulse actual dout=%0h required no pulse", dout);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("dout", 32'(dout), 32'(e.dout));
          checkOutput("parityerror", 32'(parityerror), 32'(e.par));
          checkOutput("frameerror", 32'(frameerror), 32'(e.frm));
          checkOutput("err_count", 32'(err_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic sendBit(input logic b, input int gap);
    bit_valid = 1'b1;
    rxin      = b;
    @(negedge clk);
    bit_valid = 1'b0;
    rxin      = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyStimulus(input frame_t f);
    expect_t e;
    if (f.clr) errModel = 0;
    else if ((f.expPar || f.expFrm) && errModel < 3) errModel++;
    e.dout = f.data;
    e.par  = f.expPar;
    e.frm  = f.expFrm;
    e.cnt  = 2'(errModel);
    sbQueue.push_back(e);
    lastDout = f.data;
    parity_mode = f.mode;
    sendBit(1'b0, f.gap);
    checkOutput("busy_in_frame", 32'(busy), 32'd1);
    parity_mode = ~f.mode;
    for (int i = 0; i < 8; i++) sendBit(f.data[i], f.gap);
    if (f.mode != 2'b00) sendBit(f.parBit, f.gap);
    sendBit(f.s0, f.gap);
    clr_count = f.clr;
    sendBit(f.s1, f.gap);
    clr_count = 1'b0;
  endtask

  frame_t vecA[7];
  frame_t vecB[3];
  frame_t vecC[3];

  initial begin
    //              data   mode   par   s0    s1    clr   ePar  eFrm  gap
    vecA[0] = '{8'h09, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecA[1] = '{8'h09, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecA[2] = '{8'h09, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecA[3] = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecA[4] = '{8'h3C, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecA[5] = '{8'h3C, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecA[6] = '{8'h55, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecB[0] = '{8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecB[1] = '{8'h81, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecB[2] = '{8'h55, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecC[0] = '{8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecC[1] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecC[2] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    reset = 1'b1; load = 1'b1; bit_valid = 1'b0; rxin = 1'b1;
    parity_mode = 2'b00; clr_count = 1'b0; lastDout = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecA[i]) applyStimulus(vecA[i]);

    // Reset in the middle of a data field, with the error counter saturated.
    parity_mode = 2'b01;
    sendBit(1'b0, 0);
    sendBit(1'b1, 0);
    sendBit(1'b1, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_dout", 32'(dout), 32'd0);
    checkOutput("midreset_valid", 32'(dout_valid), 32'd0);
    checkOutput("midreset_par", 32'(parityerror), 32'd0);
    checkOutput("midreset_frm", 32'(frameerror), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    errModel = 0;
    @(negedge clk);

    foreach (vecB[i]) applyStimulus(vecB[i]);

    // Abort after four data bits: no pulse may come from this frame.
    parity_mode = 2'b00;
    sendBit(1'b0, 0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 0);
    load = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_dout_held", 32'(dout), 32'h55);
    load = 1'b1;

    foreach (vecC[i]) applyStimulus(vecC[i]);

    for (int n = 0; n < 20 && sbQueue.size() != 0; n++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("dout_hold", 32'(dout), 32'(lastDout));
    checkOutput("valid_low_idle", 32'(dout_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
UART_RX_FRAME_CHECKER -- requirements
Module: uart_rx_frame_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits checked per frame; legal values 1 or 2.
REQ-003 Parameter CNT_WIDTH, default 8, width of the error counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  receive enable; low ignores all bits and aborts any frame in progress.
REQ-007 bit_valid  input  1  one-cycle strobe marking a sampled serial bit on rxin.
REQ-008 rxin  input  1  serial data bit, valid when bit_valid is high.
REQ-009 parity_mode  input  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (parity bit must be 1).
REQ-010 clr_count  input  1  synchronous clear of err_count.
REQ-011 dout  output  DATA_WIDTH  last completed frame's data, LSB received first.
REQ-012 dout_valid  output  1  one-cycle pulse when dout, parityerror and frameerror update.
REQ-013 parityerror  output  1  parity mismatch in the last completed frame.
REQ-014 frameerror  output  1  a stop bit of the last completed frame was 0.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 err_count  output  CNT_WIDTH  saturating count of frames with any error.

Function
REQ-017 FSM states: IDLE, DATA, PARITY, STOP; each transition occurs only on a clk edge with load=1 and bit_valid=1, except abort.
REQ-018 IDLE: rxin=0 (start bit) -> DATA, bit counter cleared, parity_mode latched; rxin=1 -> stay IDLE.
REQ-019 DATA: each bit shifts into a DATA_WIDTH shift register, LSB first; after the DATA_WIDTH-th bit -> PARITY if latched mode != 00, else STOP.
REQ-020 PARITY: one bit sampled; expected value = XOR of data bits for even, its inverse for odd, 1 for mark; mismatch sets internal parity flag; -> STOP.
REQ-021 STOP: STOP_BITS bits sampled; any 0 sets internal frame flag; after the last stop bit -> IDLE.
REQ-022 On the edge sampling the last stop bit: dout, parityerror and frameerror load the frame results and dout_valid rises for exactly one cycle.
REQ-023 With mode 00, parityerror is 0 at every frame completion.
REQ-024 dout, parityerror and frameerror hold their values between completions.
REQ-025 parity_mode changes mid-frame have no effect on the current frame.
REQ-026 load=0 in any non-IDLE state -> IDLE on the next edge; no dout_valid, outputs and err_count unchanged.
REQ-027 bit_valid=0 -> FSM, shift register and counters hold.
REQ-028 err_count increments by 1 at a frame completion with parity or frame flag set; it saturates at 2^CNT_WIDTH-1.
REQ-029 clr_count=1 sets err_count to 0; clr_count coinciding with an increment yields 0.
REQ-030 A start bit accepted on the cycle after completion begins a new frame with no dead cycle.

Reset
REQ-031 reset=1 on a clk edge forces IDLE, dout=0, dout_valid=0, parityerror=0, frameerror=0, busy=0, err_count=0, internal flags and counters 0; it overrides all other inputs, including mid-frame.

Verification
REQ-032 Even mode, DATA_WIDTH=8: start 0, data 0x09 LSB first, parity 0, stop 1 -> dout=0x09, dout_valid pulse, parityerror=0, frameerror=0, err_count=0.
REQ-033 Even mode: same frame with parity bit 1 -> parityerror=1, err_count=1; odd mode with parity 1 -> parityerror=0.
REQ-034 Mode 00, STOP_BITS=2: data 0xA5, stops 1 then 0 -> dout=0xA5, frameerror=1, parityerror=0, err_count increments.
REQ-035 load dropped after 4 data bits, then a full valid 0x3C frame -> no pulse for the aborted frame; one pulse with dout=0x3C.
REQ-036 CNT_WIDTH=2: five errored frames -> err_count 1,2,3,3,3; clr_count with a sixth errored completion -> 0.
REQ-037 reset asserted mid-DATA -> all outputs at reset values next cycle; following valid frame decodes correctly.
